// File: rtl/sal_cfg_pkg.sv
// rtl/sal_cfg_pkg.sv - register map, DDR2 default timings and shared types for sal_cfg_regs
package sal_cfg_pkg;

  localparam int NUM_TIMING = 10;
  localparam int TFIELD_W   = 16;

  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_STATUS  = 8'h04;
  localparam logic [7:0] OFF_RCD     = 8'h08;
  localparam logic [7:0] OFF_RTW     = 8'h2C;
  localparam logic [7:0] OFF_VERSION = 8'h30;

  localparam logic [5:0] IDX_CTRL    = OFF_CTRL[7:2];
  localparam logic [5:0] IDX_STATUS  = OFF_STATUS[7:2];
  localparam logic [5:0] IDX_FIRST_T = OFF_RCD[7:2];
  localparam logic [5:0] IDX_LAST_T  = OFF_RTW[7:2];
  localparam logic [5:0] IDX_VERSION = OFF_VERSION[7:2];

  localparam logic [31:0] VERSION = 32'h0001_0000;

  typedef logic [TFIELD_W-1:0] tfield_t;

  // Field order matches the shadow register order in the map.
  typedef struct packed {
    tfield_t rcd;
    tfield_t rp;
    tfield_t ras;
    tfield_t rfc;
    tfield_t rtp;
    tfield_t wtp;
    tfield_t rrd;
    tfield_t ccd;
    tfield_t wtr;
    tfield_t rtw;
  } timing_set_t;

  localparam timing_set_t DDR2_DEFAULTS = '{
    rcd: 16'd5,  rp: 16'd5,  ras: 16'd18, rfc: 16'd51, rtp: 16'd3,
    wtp: 16'd13, rrd: 16'd3, ccd: 16'd2,  wtr: 16'd3,  rtw: 16'd4
  };

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_e;

  function automatic tfield_t timing_field(timing_set_t s, int idx);
    return s[(NUM_TIMING - 1 - idx) * TFIELD_W +: TFIELD_W];
  endfunction

endpackage

// File: rtl/sal_cfg_regs_if.sv
// rtl/sal_cfg_regs_if.sv - APB slave bus and active timing source interfaces
interface APB_IF #(parameter int ADDR_W = 12) ();
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
endinterface

interface BK_TIMING_IF #(parameter int TIMING_W = 8) ();
  logic [TIMING_W-1:0] t_rcd;
  logic [TIMING_W-1:0] t_rp;
  logic [TIMING_W-1:0] t_ras;
  logic [TIMING_W-1:0] t_rfc;
  logic [TIMING_W-1:0] t_rtp;
  logic [TIMING_W-1:0] t_wtp;

  modport SRC (output t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp);
  modport SNK (input  t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp);
endinterface

interface SCHED_TIMING_IF #(parameter int TIMING_W = 8) ();
  logic [TIMING_W-1:0] t_rrd;
  logic [TIMING_W-1:0] t_ccd;
  logic [TIMING_W-1:0] t_wtr;
  logic [TIMING_W-1:0] t_rtw;

  modport SRC (output t_rrd, t_ccd, t_wtr, t_rtw);
  modport SNK (input  t_rrd, t_ccd, t_wtr, t_rtw);
endinterface

// File: rtl/sal_cfg_apb_slv.sv
// rtl/sal_cfg_apb_slv.sv - APB slave FSM with programmable wait states; emits single-cycle register strobes
module sal_cfg_apb_slv
  import sal_cfg_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  APB_IF.slave              apb,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  input  logic [31:0]       rdata,
  input  logic              err
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  apb_state_e state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= APB_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // The setup phase is recognised from the bus itself so that a zero-wait
  // slave answers in the first access-phase cycle.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    done    = 1'b0;
    case (state_q)
      APB_IDLE, APB_SETUP: begin
        if (apb.psel && !apb.penable) begin
          state_d = APB_ACCESS;
          wait_d  = WAIT_INIT;
        end else if (!apb.psel) begin
          state_d = APB_IDLE;
        end
      end
      APB_ACCESS: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          done    = 1'b1;
          state_d = apb.psel ? APB_SETUP : APB_IDLE;
        end
      end
      default: state_d = APB_IDLE;
    endcase
  end

  assign wr_en = done && apb.pwrite;
  assign rd_en = done && !apb.pwrite;
  assign addr  = apb.paddr;
  assign wdata = apb.pwdata;

  assign apb.pready  = done;
  assign apb.prdata  = done ? rdata : 32'd0;
  assign apb.pslverr = done && err;

endmodule

// File: rtl/sal_cfg_regs.sv
// rtl/sal_cfg_regs.sv - DRAM timing shadow/active register file with idle-gated atomic commit
module sal_cfg_regs
  import sal_cfg_pkg::*;
#(
  parameter int TIMING_W    = 8,
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst,
  APB_IF.slave            apb_if,
  BK_TIMING_IF.SRC        bk_timing_if,
  SCHED_TIMING_IF.SRC     sched_timing_if,
  input  logic            idle_i,
  output logic            commit_done_o
);

  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              err;

  sal_cfg_apb_slv #(
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_apb_slv (
    .clk   (clk),
    .rst   (rst),
    .apb   (apb_if),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .err   (err)
  );

  logic [TIMING_W-1:0] shadow_q [NUM_TIMING];
  logic [TIMING_W-1:0] active_q [NUM_TIMING];
  logic                pending_q;
  logic                error_q;
  logic                commit_done_q;

  logic [5:0] idx;
  logic [3:0] t_sel;
  logic       is_timing;
  logic       mapped;
  logic       wr_err;
  logic       rd_err;
  logic       wr_ok;
  logic       commit_fire;
  logic       unused_bits;

  assign idx       = addr[7:2];
  assign t_sel     = idx[3:0] - IDX_FIRST_T[3:0];
  assign is_timing = (idx >= IDX_FIRST_T) && (idx <= IDX_LAST_T);
  assign mapped    = (idx <= IDX_VERSION);

  // Timing writes are refused while a commit is outstanding so the set
  // being committed cannot be torn.
  assign wr_err = !mapped
               || (idx == IDX_STATUS && wdata[0])
               || (idx == IDX_VERSION)
               || (is_timing && (wdata[TIMING_W-1:0] == '0 || pending_q));
  assign rd_err = !mapped;
  assign err    = (wr_en && wr_err) || (rd_en && rd_err);

  assign wr_ok       = wr_en && !wr_err;
  assign commit_fire = pending_q && idle_i;

  always_comb begin
    rdata = 32'd0;
    if (rd_en && !rd_err) begin
      if (idx == IDX_STATUS)       rdata = {30'd0, error_q, pending_q};
      else if (idx == IDX_VERSION) rdata = VERSION;
      else if (is_timing)          rdata = 32'(shadow_q[t_sel]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TIMING; i++) begin
        shadow_q[i] <= TIMING_W'(timing_field(DDR2_DEFAULTS, i));
        active_q[i] <= TIMING_W'(timing_field(DDR2_DEFAULTS, i));
      end
      pending_q     <= 1'b0;
      error_q       <= 1'b0;
      commit_done_q <= 1'b0;
    end else begin
      commit_done_q <= commit_fire;

      if (commit_fire) begin
        for (int i = 0; i < NUM_TIMING; i++) active_q[i] <= shadow_q[i];
        pending_q <= 1'b0;
      end else if (wr_ok && idx == IDX_CTRL && wdata[0]) begin
        pending_q <= 1'b1;
      end

      if (wr_ok && is_timing) shadow_q[t_sel] <= wdata[TIMING_W-1:0];

      if (err)                                         error_q <= 1'b1;
      else if (wr_ok && idx == IDX_STATUS && wdata[1]) error_q <= 1'b0;
    end
  end

  assign commit_done_o = commit_done_q;

  assign bk_timing_if.t_rcd = active_q[0];
  assign bk_timing_if.t_rp  = active_q[1];
  assign bk_timing_if.t_ras = active_q[2];
  assign bk_timing_if.t_rfc = active_q[3];
  assign bk_timing_if.t_rtp = active_q[4];
  assign bk_timing_if.t_wtp = active_q[5];

  assign sched_timing_if.t_rrd = active_q[6];
  assign sched_timing_if.t_ccd = active_q[7];
  assign sched_timing_if.t_wtr = active_q[8];
  assign sched_timing_if.t_rtw = active_q[9];

  assign unused_bits = ^{addr[ADDR_W-1:8], addr[1:0], wdata[31:TIMING_W]};

endmodule

// File: tb/tb_sal_cfg_regs.sv
// tb/tb_sal_cfg_regs.sv - directed self-checking bench for sal_cfg_regs (WAIT_CYCLES=3)
module tb_sal_cfg_regs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic idle_i = 1'b1;
  logic commit_done_o;

  int checks = 0;
  int failures = 0;
  int acc;
  logic [31:0] rd;
  logic        serr;
  logic [7:0]  dflt [10];
  logic [7:0]  act_obs [10];
  int          pulses;

  APB_IF #(.ADDR_W(12))            apb_bus ();
  BK_TIMING_IF #(.TIMING_W(8))     bk_bus ();
  SCHED_TIMING_IF #(.TIMING_W(8))  sched_bus ();

  sal_cfg_regs #(.TIMING_W(8), .ADDR_W(12), .WAIT_CYCLES(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .apb_if          (apb_bus),
    .bk_timing_if    (bk_bus),
    .sched_timing_if (sched_bus),
    .idle_i          (idle_i),
    .commit_done_o   (commit_done_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    act_obs[0] = bk_bus.t_rcd;
    act_obs[1] = bk_bus.t_rp;
    act_obs[2] = bk_bus.t_ras;
    act_obs[3] = bk_bus.t_rfc;
    act_obs[4] = bk_bus.t_rtp;
    act_obs[5] = bk_bus.t_wtp;
    act_obs[6] = sched_bus.t_rrd;
    act_obs[7] = sched_bus.t_ccd;
    act_obs[8] = sched_bus.t_wtr;
    act_obs[9] = sched_bus.t_rtw;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the completing edge.
  task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d,
                     output logic [31:0] rdata, output logic err, output int n);
    apb_bus.psel = 1'b1; apb_bus.penable = 1'b0;
    apb_bus.pwrite = wr; apb_bus.paddr = a; apb_bus.pwdata = d;
    @(posedge clk); #1 apb_bus.penable = 1'b1;
    n = 1;
    @(negedge clk);
    while (!apb_bus.pready && n < 32) begin @(negedge clk); n++; end
    if (n >= 32) begin
      checks++; failures++;
      $display("FAIL pready_timeout observed=0 expected=1 addr=0x%0h", a);
    end
    rdata = apb_bus.prdata; err = apb_bus.pslverr;
    @(posedge clk); #1 apb_bus.psel = 1'b0; apb_bus.penable = 1'b0;
  endtask

  task automatic wr_chk(input string tag, input logic [11:0] a, input logic [31:0] d,
                        input logic exp_err);
    logic [31:0] r; logic e; int n;
    apb(1'b1, a, d, r, e, n);
    check({tag, "_pslverr"}, 32'(e), 32'(exp_err));
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp,
                        input logic exp_err);
    logic [31:0] r; logic e; int n;
    apb(1'b0, a, 32'd0, r, e, n);
    check({tag, "_prdata"}, r, exp);
    check({tag, "_pslverr"}, 32'(e), 32'(exp_err));
  endtask

  initial begin
    dflt[0] = 8'd5;  dflt[1] = 8'd5; dflt[2] = 8'h12; dflt[3] = 8'h33; dflt[4] = 8'd3;
    dflt[5] = 8'h0D; dflt[6] = 8'd3; dflt[7] = 8'd2;  dflt[8] = 8'd3;  dflt[9] = 8'd4;
    apb_bus.psel = 1'b0; apb_bus.penable = 1'b0; apb_bus.pwrite = 1'b0;
    apb_bus.paddr = '0; apb_bus.pwdata = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_pready", 32'(apb_bus.pready), 32'd0);
    check("rst_pslverr", 32'(apb_bus.pslverr), 32'd0);
    check("rst_prdata", apb_bus.prdata, 32'd0);
    check("rst_commit_done", 32'(commit_done_o), 32'd0);
    for (int i = 0; i < 10; i++) check($sformatf("rst_active%0d", i), 32'(act_obs[i]), 32'(dflt[i]));

    // Full map readback; first read also checks wait-state count
    apb(1'b0, 12'h000, 32'd0, rd, serr, acc);
    check("wait_cycles_first", 32'(acc), 32'd4);
    check("ctrl_read", rd, 32'd0);
    rd_chk("status_rst", 12'h004, 32'd0, 1'b0);
    for (int i = 0; i < 10; i++) rd_chk($sformatf("shadow_rst%0d", i), 12'(8 + 4 * i), 32'(dflt[i]), 1'b0);
    rd_chk("version", 12'h030, 32'h0001_0000, 1'b0);

    // Commit held off by idle_i
    idle_i = 1'b0;
    wr_chk("wr_rcd7", 12'h008, 32'h7, 1'b0);
    wr_chk("commit1", 12'h000, 32'h1, 1'b0);
    rd_chk("status_pending", 12'h004, 32'h1, 1'b0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (commit_done_o) pulses++;
      check("rcd_held", 32'(bk_bus.t_rcd), 32'd5);
    end
    @(posedge clk); #1 idle_i = 1'b1;
    @(negedge clk);
    check("rcd_before_commit_edge", 32'(bk_bus.t_rcd), 32'd5);
    check("done_before_commit_edge", 32'(commit_done_o), 32'd0);
    @(posedge clk); #1;
    check("rcd_committed", 32'(bk_bus.t_rcd), 32'd7);
    check("done_pulse", 32'(commit_done_o), 32'd1);
    @(posedge clk); #1;
    check("done_low_after", 32'(commit_done_o), 32'd0);
    check("no_early_pulse", 32'(pulses), 32'd0);
    rd_chk("status_cleared", 12'h004, 32'd0, 1'b0);

    // Minimum commit latency with idle_i held high
    wr_chk("commit2", 12'h000, 32'h1, 1'b0);
    check("latency_c1", 32'(commit_done_o), 32'd0);
    @(posedge clk); #1;
    check("latency_c2", 32'(commit_done_o), 32'd1);

    // Writes refused while pending; double COMMIT is a no-op
    @(posedge clk); #1 idle_i = 1'b0;
    wr_chk("commit3", 12'h000, 32'h1, 1'b0);
    wr_chk("commit3_again", 12'h000, 32'h1, 1'b0);
    wr_chk("wr_rp_pending", 12'h00C, 32'h9, 1'b1);
    rd_chk("rp_unchanged", 12'h00C, 32'd5, 1'b0);
    rd_chk("status_pend_err", 12'h004, 32'h3, 1'b0);
    wr_chk("clear_err", 12'h004, 32'h2, 1'b0);
    rd_chk("status_err_clr", 12'h004, 32'h1, 1'b0);
    idle_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (commit_done_o) pulses++; end
    check("single_pulse", 32'(pulses), 32'd1);

    // Error responses with no state change
    @(posedge clk); #1;
    wr_chk("wr_ras_zero", 12'h010, 32'h0, 1'b1);
    wr_chk("wr_unmapped", 12'h034, 32'h5, 1'b1);
    wr_chk("wr_version", 12'h030, 32'h5, 1'b1);
    wr_chk("wr_status_b0", 12'h004, 32'h1, 1'b1);
    rd_chk("rd_unmapped", 12'h034, 32'd0, 1'b1);
    rd_chk("ras_unchanged", 12'h010, 32'h12, 1'b0);
    rd_chk("version_unchanged", 12'h030, 32'h0001_0000, 1'b0);
    rd_chk("status_sticky", 12'h004, 32'h2, 1'b0);
    wr_chk("wr_rtw_masked0", 12'h02C, 32'h100, 1'b1);
    rd_chk("rtw_unchanged", 12'h02C, 32'd4, 1'b0);
    wr_chk("clear_err2", 12'h004, 32'h2, 1'b0);

    // Field masking and back-to-back access timing
    wr_chk("wr_rfc_1ff", 12'h014, 32'h1FF, 1'b0);
    apb(1'b0, 12'h014, 32'd0, rd, serr, acc);
    check("rfc_masked", rd, 32'hFF);
    check("b2b_wait_cycles", 32'(acc), 32'd4);

    // Reset during an access wait state with a commit pending
    idle_i = 1'b0;
    wr_chk("commit4", 12'h000, 32'h1, 1'b0);
    apb_bus.psel = 1'b1; apb_bus.penable = 1'b0; apb_bus.pwrite = 1'b0; apb_bus.paddr = 12'h008;
    @(posedge clk); #1 apb_bus.penable = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_pready", 32'(apb_bus.pready), 32'd0);
    @(posedge clk); #1 rst = 1'b0; apb_bus.psel = 1'b0; apb_bus.penable = 1'b0; idle_i = 1'b1;
    check("postrst_pready", 32'(apb_bus.pready), 32'd0);
    for (int i = 0; i < 10; i++) check($sformatf("postrst_active%0d", i), 32'(act_obs[i]), 32'(dflt[i]));
    pulses = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (commit_done_o) pulses++; end
    check("postrst_no_pulse", 32'(pulses), 32'd0);
    @(posedge clk); #1;
    rd_chk("postrst_status", 12'h004, 32'd0, 1'b0);
    rd_chk("postrst_rcd", 12'h008, 32'd5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sal_cfg_regs.md
# sal_cfg_regs

APB-programmable DRAM timing configuration block for the DDR2 controller. It holds a shadow register per timing parameter and an active set that drives the bank and scheduler timing interfaces. Software writes the shadow set, then requests a commit. The active set is updated atomically only when the controller reports idle, so timing never changes mid-command. It generalises the fixed-constant timing source with parametrised field width, APB wait states, readback, error responses and a commit handshake.

## Interface
Parameters:
- TIMING_W, 8: width of every timing field; write data above bit TIMING_W-1 is ignored.
- ADDR_W, 12: APB address width decoded; only PADDR[7:2] is significant.
- WAIT_CYCLES, 0: wait states inserted in the APB access phase (0..15).

Ports:
- clk  input  1  clock; the only clock.
- rst  input  1  reset, synchronous, active-high.
- apb_if  APB_IF  -  APB slave (PSEL, PENABLE, PWRITE, PADDR, PWDATA[31:0], PRDATA[31:0], PREADY, PSLVERR).
- bk_timing_if  BK_TIMING_IF.SRC  -  active t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp.
- sched_timing_if  SCHED_TIMING_IF.SRC  -  active t_rrd, t_ccd, t_wtr, t_rtw.
- idle_i  input  1  controller has no command in flight; commit is permitted.
- commit_done_o  output  1  one-cycle pulse when the active set is updated.

## Operation
- Register map (word offsets):
  - 0x00 CTRL: bit0 COMMIT, write-1-to-request; always reads 0.
  - 0x04 STATUS (RO): bit0 commit_pending; bit1 sticky error, cleared by writing 1 to bit1.
  - 0x08..0x2C shadow registers, in this order: RCD, RP, RAS, RFC, RTP, WTP, RRD, CCD, WTR, RTW. Reads return the zero-extended shadow value.
  - 0x30 VERSION (RO): constant 0x0001_0000.
- PSLVERR=1 with the completing PREADY, with no state change, sticky error set, for each of:
  - unmapped offset;
  - write to STATUS bit0 or to VERSION;
  - write of value 0 (after masking to TIMING_W) to a timing register;
  - write to any timing register while commit_pending=1.
- Errored reads return PRDATA=0.
- Commit:
  - A COMMIT write sets pending.
  - Starting the cycle after that write completes, the first cycle with pending=1 and idle_i=1 copies all 10 shadows to active at the next edge, clears pending and pulses commit_done_o.
  - COMMIT written while pending is already 1 is accepted as a no-op.
- Reset: shadow and active = package defaults (DDR2 timing values); pending=0, error=0, commit_done_o=0, PREADY=0, PSLVERR=0, PRDATA=0.
- Reset asserted mid-transfer or mid-commit abandons the transfer; active reverts to defaults.

## Timing
- APB FSM states: IDLE → SETUP (PSEL & !PENABLE) → ACCESS.
- ACCESS holds PREADY=0 for WAIT_CYCLES cycles, counted by a 4-bit down-counter, then asserts PREADY=1 for exactly one cycle and returns to IDLE, or to SETUP if PSEL is still high.
- With WAIT_CYCLES=0, PREADY is high in the first ACCESS cycle.
- Register writes take effect at the edge where PREADY=1. PRDATA and PSLVERR are valid when PREADY=1 and 0 otherwise.
- Active outputs are registered and change only on the commit edge. commit_done_o is high in the cycle after that edge.
- Minimum latency from COMMIT write completion to commit_done_o: 2 cycles with idle_i held high.

## Structure
- Package sal_cfg_pkg holds:
  - register offset localparams, VERSION constant;
  - default timing values taken from the shared DDR parameter header;
  - a typedef packing the 10 timing fields.
- Sub-module sal_cfg_apb_slv: APB FSM and wait counter, exposing single-cycle wr_en, rd_en, addr, wdata and returning rdata and err. The top level holds the register file, decode and commit logic.

## Test plan
- Reset, then read all offsets → shadows equal the defaults, STATUS=0, VERSION=0x0001_0000; interface outputs equal the defaults.
- Write RCD=0x7, COMMIT, hold idle_i=0 for 20 cycles, then raise it → t_rcd stays at default until 1 cycle after idle_i rises; commit_done_o pulses once; STATUS.pending returns to 0.
- With pending=1, write RP=0x9 → PSLVERR=1, RP shadow unchanged, STATUS.bit1=1; write 0x2 to STATUS → bit1 clears.
- Write 0 to RAS, write to offset 0x34, write to VERSION → PSLVERR on each, no register changes.
- WAIT_CYCLES=3: back-to-back read of RFC → PREADY rises on the 4th ACCESS cycle; 0x1FF written with TIMING_W=8 reads back 0xFF.
- Assert rst during an ACCESS wait state with pending=1 → PREADY=0, pending=0, outputs at defaults, no commit_done_o pulse.
